tick_address_sequencer: RTL and testbench

TICK_ADDRESS_SEQUENCER -- requirements
Module: tick_address_sequencer

---
 rtl/tick_seq_pkg.sv | 14 +
 rtl/tick_edge_detect.sv | 32 +++
 rtl/tick_address_sequencer.sv | 116 +++++++++++
 tb/tb_tick_address_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tick_seq_pkg.sv
// tick_seq_pkg
//   Shared definitions for the tick address sequencer:
//     state_t     - sequencer FSM states (IDLE, RUN)
//     ADDR_W_DEF  - default address width
package tick_seq_pkg;

   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect
//   Registers the raw Enable level and emits a single-cycle Tick on each
//   0->1 transition. A level held for many cycles produces one tick. The
//   tick comes out of registers, so it lags the Enable edge by one cycle.
//   Ports:
//     Clk    - system clock, rising edge
//     Reset  - synchronous active-high, clears both history registers
//     Enable - raw advance level from the timer
//     Tick   - one-cycle pulse per rising edge of Enable
module tick_edge_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic Enable,
   output logic Tick
);

   logic en_q;   // Enable sampled this cycle
   logic en_qq;  // Enable sampled the cycle before

   always_ff @(posedge Clk) begin
      if (Reset) begin
         en_q  <= 1'b0;
         en_qq <= 1'b0;
      end else begin
         en_q  <= Enable;
         en_qq <= en_q;
      end
   end

   assign Tick = en_q & ~en_qq;

endmodule

// File: rtl/tick_address_sequencer.sv
// tick_address_sequencer
//   Walks Address from a latched start to a latched end bound, one step per
//   tick, either once (Done pulse at the end) or repeatedly (Wrap pulse on
//   each reload). Direction, loop mode and bounds are captured at Start.
//   Build option: define TICK_EDGE_EN to count only rising edges of Enable
//   (one extra cycle of latency); otherwise every Enable=1 cycle is a tick.
//   Ports:
//     Clk, Reset          - clock and synchronous active-high reset
//     Enable              - advance tick from the timer
//     Start / Stop        - (re)start or abort a sequence; Stop wins
//     Loop, Dir           - repeat mode and count direction (1 = down)
//     StartAddr, EndAddr  - range bounds
//     Address             - registered current address
//     Busy                - high while running
//     Done, Wrap          - one-cycle completion / loop-restart pulses
module tick_address_sequencer
   import tick_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Enable,
   input  logic              Start,
   input  logic              Stop,
   input  logic              Loop,
   input  logic              Dir,
   input  logic [ADDR_W-1:0] StartAddr,
   input  logic [ADDR_W-1:0] EndAddr,
   output logic [ADDR_W-1:0] Address,
   output logic              Busy,
   output logic              Done,
   output logic              Wrap
);

   state_t            state;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] end_q;
   logic              loop_q;
   logic              dir_q;
   logic              tick;

`ifdef TICK_EDGE_EN
   tick_edge_detect u_edge (
      .Clk    (Clk),
      .Reset  (Reset),
      .Enable (Enable),
      .Tick   (tick)
   );
`else
   assign tick = Enable;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         Address <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Wrap    <= 1'b0;
         start_q <= '0;
         end_q   <= '0;
         loop_q  <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         // pulses default low so they last exactly one cycle
         Done <= 1'b0;
         Wrap <= 1'b0;
         case (state)
            IDLE: begin
               // ticks are ignored here, even one coincident with Start
               if (Start && !Stop) begin
                  start_q <= StartAddr;
                  end_q   <= EndAddr;
                  loop_q  <= Loop;
                  dir_q   <= Dir;
                  Address <= StartAddr;
                  Busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (Stop) begin
                  // abort: Address holds, no pulse
                  Busy  <= 1'b0;
                  state <= IDLE;
               end else if (Start) begin
                  // restart overrides any coincident tick
                  start_q <= StartAddr;
                  end_q   <= EndAddr;
                  loop_q  <= Loop;
                  dir_q   <= Dir;
                  Address <= StartAddr;
               end else if (tick) begin
                  if (Address != end_q) begin
                     // modulo step, so ranges may cross zero in either direction
                     Address <= dir_q ? Address - ADDR_W'(1) : Address + ADDR_W'(1);
                  end else if (loop_q) begin
                     Address <= start_q;
                     Wrap    <= 1'b1;
                  end else begin
                     Done  <= 1'b1;
                     Busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tick_address_sequencer.sv
// tb_tick_address_sequencer
//   Directed vectors for tick_address_sequencer (ADDR_W=5). Each driven
//   cycle pushes the hand-computed outputs expected after the next rising
//   edge into a queue; an independent monitor pops and compares them on the
//   falling edge of the cycle they fall due.
module tb_tick_address_sequencer;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Enable = 1'b0;
   logic       Start = 1'b0;
   logic       Stop = 1'b0;
   logic       Loop = 1'b0;
   logic       Dir = 1'b0;
   logic [4:0] StartAddr = '0;
   logic [4:0] EndAddr = '0;
   logic [4:0] Address;
   logic       Busy, Done, Wrap;

   tick_address_sequencer #(.ADDR_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Start(Start), .Stop(Stop),
      .Loop(Loop), .Dir(Dir), .StartAddr(StartAddr), .EndAddr(EndAddr),
      .Address(Address), .Busy(Busy), .Done(Done), .Wrap(Wrap)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         due;
      int         id;
      logic [4:0] a;
      logic       b, d, w;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   vec_id = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // monitor: compare every expected entry that falls due this cycle
   always @(negedge Clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         n_checks++;
         if (e.due != cyc || Address !== e.a || Busy !== e.b || Done !== e.d || Wrap !== e.w) begin
            n_fail++;
            $display("FAIL vec%0d cyc%0d: got addr=%0d busy=%b done=%b wrap=%b, want addr=%0d busy=%b done=%b wrap=%b (due %0d)",
                     e.id, cyc, Address, Busy, Done, Wrap, e.a, e.b, e.d, e.w, e.due);
         end
      end
   end

   // drive one cycle of inputs and queue the outputs expected after the edge
   task automatic vec(input logic rst, st, sp, en, lp, dr,
                      input logic [4:0] sa, ea,
                      input logic [4:0] xa, input logic xb, xd, xw);
      exp_t e;
      @(posedge Clk);
      #1;
      Reset = rst; Start = st; Stop = sp; Enable = en;
      Loop = lp; Dir = dr; StartAddr = sa; EndAddr = ea;
      e.due = cyc + 1; e.id = vec_id; e.a = xa; e.b = xb; e.d = xd; e.w = xw;
      q.push_back(e);
      vec_id++;
   endtask

   // shorthands: plain tick / idle cycle, and a start
   task automatic tk(input logic en, input logic [4:0] xa, input logic xb, xd, xw);
      vec(1'b0, 1'b0, 1'b0, en, 1'b0, 1'b0, 5'd0, 5'd0, xa, xb, xd, xw);
   endtask

   task automatic st(input logic lp, dr, input logic [4:0] sa, ea);
      vec(1'b0, 1'b1, 1'b0, 1'b0, lp, dr, sa, ea, sa, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      // reset state
      vec(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      vec(1, 1, 0, 1, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);

`ifdef TICK_EDGE_EN
      // a 10-cycle Enable level gives one step, two cycles after its edge
      st(0, 0, 5'd0, 5'd31);
      tk(1, 5'd0, 1, 0, 0);
      for (int i = 0; i < 9; i++) tk(1, 5'd1, 1, 0, 0);
      tk(0, 5'd1, 1, 0, 0);
      tk(0, 5'd1, 1, 0, 0);
      // reset mid-run clears everything with no pulse
      vec(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      tk(1, 5'd0, 0, 0, 0);
`else
      // up one-shot 3..6; Enable coincident with Start is ignored
      vec(0, 1, 0, 1, 0, 0, 5'd3, 5'd6, 5'd3, 1, 0, 0);
      tk(1, 5'd4, 1, 0, 0);
      tk(0, 5'd4, 1, 0, 0);
      tk(1, 5'd5, 1, 0, 0);
      tk(1, 5'd6, 1, 0, 0);
      tk(1, 5'd6, 0, 1, 0);
      tk(0, 5'd6, 0, 0, 0);
      tk(1, 5'd6, 0, 0, 0);   // Enable in IDLE does nothing

      // down loop 2..0
      st(1, 1, 5'd2, 5'd0);
      tk(1, 5'd1, 1, 0, 0);
      tk(1, 5'd0, 1, 0, 0);
      tk(1, 5'd2, 1, 0, 1);
      tk(1, 5'd1, 1, 0, 0);
      tk(1, 5'd0, 1, 0, 0);
      vec(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

      // zero-crossing up range 30..1
      st(0, 0, 5'd30, 5'd1);
      tk(1, 5'd31, 1, 0, 0);
      tk(1, 5'd0, 1, 0, 0);
      tk(1, 5'd1, 1, 0, 0);
      tk(1, 5'd1, 0, 1, 0);

      // Stop beats Start and Enable at Address 5
      st(1, 0, 5'd3, 5'd10);
      tk(1, 5'd4, 1, 0, 0);
      tk(1, 5'd5, 1, 0, 0);
      vec(0, 1, 1, 1, 0, 0, 5'd0, 5'd2, 5'd5, 0, 0, 0);
      tk(0, 5'd5, 0, 0, 0);

      // restart in RUN ignores the coincident tick
      st(0, 0, 5'd7, 5'd9);
      tk(1, 5'd8, 1, 0, 0);
      vec(0, 1, 0, 1, 0, 0, 5'd20, 5'd21, 5'd20, 1, 0, 0);
      tk(1, 5'd21, 1, 0, 0);
      tk(1, 5'd21, 0, 1, 0);

      // reset mid-run at Address 4
      st(0, 0, 5'd2, 5'd9);
      tk(1, 5'd3, 1, 0, 0);
      tk(1, 5'd4, 1, 0, 0);
      vec(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      tk(1, 5'd0, 0, 0, 0);

      // one-address range: loop wraps every tick, one-shot finishes at once
      st(1, 0, 5'd12, 5'd12);
      tk(1, 5'd12, 1, 0, 1);
      tk(1, 5'd12, 1, 0, 1);
      vec(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd12, 0, 0, 0);
      st(0, 1, 5'd12, 5'd12);
      tk(1, 5'd12, 0, 1, 0);
      tk(0, 5'd12, 0, 0, 0);
`endif

      // let the monitor drain, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
